// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN layer controllers.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    NEXT
  } seq_state_t;

  // Output side length of a valid (unpadded) convolution.
  function automatic int conv_out_side(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Read-side and write-side base-plus-offset address counters; each base
// advances by its step per map so no multiplier is needed.
module seq_addr_gen #(
  parameter int ADDR_W  = 10,
  parameter int RD_STEP = 16,
  parameter int WR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_clr_i,
  input  logic              rd_next_i,
  input  logic              rd_inc_i,
  input  logic              wr_clr_i,
  input  logic              wr_next_i,
  input  logic              wr_inc_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] rd_off_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] wr_off_o
);

  logic [ADDR_W-1:0] rdBase_q, rdBase_d, rdOff_q, rdOff_d;
  logic [ADDR_W-1:0] wrBase_q, wrBase_d, wrOff_q, wrOff_d;

  always_comb begin
    rdBase_d = rdBase_q;
    rdOff_d  = rdOff_q;
    wrBase_d = wrBase_q;
    wrOff_d  = wrOff_q;
    if (rd_clr_i) begin
      rdBase_d = '0;
      rdOff_d  = '0;
    end else if (rd_next_i) begin
      rdBase_d = rdBase_q + ADDR_W'(RD_STEP);
      rdOff_d  = '0;
    end else if (rd_inc_i) begin
      rdOff_d = rdOff_q + 1'b1;
    end
    if (wr_clr_i) begin
      wrBase_d = '0;
      wrOff_d  = '0;
    end else if (wr_next_i) begin
      wrBase_d = wrBase_q + ADDR_W'(WR_STEP);
      wrOff_d  = '0;
    end else if (wr_inc_i) begin
      wrOff_d = wrOff_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdBase_q <= '0;
      rdOff_q  <= '0;
      wrBase_q <= '0;
      wrOff_q  <= '0;
    end else begin
      rdBase_q <= rdBase_d;
      rdOff_q  <= rdOff_d;
      wrBase_q <= wrBase_d;
      wrOff_q  <= wrOff_d;
    end
  end

  assign rd_addr_o = rdBase_q + rdOff_q;
  assign rd_off_o  = rdOff_q;
  assign wr_addr_o = wrBase_q + wrOff_q;
  assign wr_off_o  = wrOff_q;

endmodule

// File: rtl/conv_sequencer.sv
// Walks NUM_MAPS feature maps through one streaming convolver: clear, stream
// activations from a synchronous RAM, then pack valid results into an output RAM.
module conv_sequencer
  import cnn_pkg::*;
#(
  parameter int N         = 4,
  parameter int K         = 3,
  parameter int S         = 1,
  parameter int NUM_MAPS  = 1,
  parameter int ACT_W     = 16,
  parameter int OUT_W     = 32,
  parameter int ADDR_W    = 10,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              global_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [ACT_W-1:0]  act_rd_data,
  output logic              conv_rst,
  output logic              conv_ce,
  output logic [ACT_W-1:0]  conv_act,
  input  logic [OUT_W-1:0]  conv_op,
  input  logic              conv_valid,
  input  logic              conv_end,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [OUT_W-1:0]  out_wr_data
);

  localparam int MAP_SZ = N * N;
  localparam int O      = conv_out_side(N, K, S);
  localparam int OUT_SZ = O * O;
  localparam int MAP_W  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
  localparam int DRN_W  = $clog2(DRAIN_MAX + 1);

  localparam logic [ADDR_W-1:0] MAP_LAST = ADDR_W'(MAP_SZ - 1);
  localparam logic [ADDR_W-1:0] OUT_FULL = ADDR_W'(OUT_SZ);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_SZ - 1);
  localparam logic [MAP_W-1:0]  MAP_IDX_LAST = MAP_W'(NUM_MAPS - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_MAX - 1);

  seq_state_t        state_q, state_d;
  logic [MAP_W-1:0]  map_q, map_d;
  logic [DRN_W-1:0]  drainCnt_q, drainCnt_d;
  logic              err_q, err_d, done_q, done_d;
  logic              rdDly_q;
  logic              wrEn_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [OUT_W-1:0]  wrData_q;

  logic              accept, capture, earlyEnd;
  logic              rdClr, rdNext, rdInc, wrClr, wrNext;
  logic [ADDR_W-1:0] rdAddr, rdOff, wrAddr, wrOff;

  seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .RD_STEP(MAP_SZ),
    .WR_STEP(OUT_SZ)
  ) u_addr (
    .clk      (clk),
    .rst      (global_rst),
    .rd_clr_i (rdClr),
    .rd_next_i(rdNext),
    .rd_inc_i (rdInc),
    .wr_clr_i (wrClr),
    .wr_next_i(wrNext),
    .wr_inc_i (capture),
    .rd_addr_o(rdAddr),
    .rd_off_o (rdOff),
    .wr_addr_o(wrAddr),
    .wr_off_o (wrOff)
  );

  // A start coinciding with done is refused so a run never restarts back-to-back.
  assign accept   = (state_q == IDLE) && start && !done_q;
  assign capture  = (state_q inside {STREAM, DRAIN, NEXT}) && conv_valid && (wrOff < OUT_FULL);
  assign earlyEnd = (state_q inside {STREAM, DRAIN}) && conv_end && !conv_valid
                    && (wrOff < OUT_LAST);

  always_comb begin
    state_d    = state_q;
    map_d      = map_q;
    err_d      = err_q;
    done_d     = 1'b0;
    drainCnt_d = '0;
    rdClr      = 1'b0;
    rdNext     = 1'b0;
    rdInc      = 1'b0;
    wrClr      = 1'b0;
    wrNext     = 1'b0;
    if (earlyEnd) err_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CLEAR;
          map_d   = '0;
          err_d   = 1'b0;
          rdClr   = 1'b1;
          wrClr   = 1'b1;
        end
      end
      CLEAR: state_d = STREAM;
      STREAM: begin
        rdInc = 1'b1;
        if (rdOff == MAP_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q + 1'b1;
        if (wrOff == OUT_FULL) begin
          if (map_q == MAP_IDX_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = NEXT;
          end
        end else if (drainCnt_q == DRN_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      NEXT: begin
        map_d   = map_q + 1'b1;
        rdNext  = 1'b1;
        wrNext  = 1'b1;
        state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q    <= IDLE;
      map_q      <= '0;
      drainCnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rdDly_q    <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      drainCnt_q <= drainCnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rdDly_q    <= act_rd_en;
      wrEn_q     <= capture;
      if (capture) begin
        wrAddr_q <= wrAddr;
        wrData_q <= conv_op;
      end
    end
  end

  // RAM data lands one cycle after the strobe, so ce follows the delayed strobe.
  assign act_rd_en   = (state_q == STREAM);
  assign act_rd_addr = rdAddr;
  assign conv_rst    = (state_q == CLEAR);
  assign conv_ce     = ((state_q == STREAM) && rdDly_q) || (state_q == DRAIN);
  assign conv_act    = rdDly_q ? act_rd_data : '0;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign out_wr_en   = wrEn_q;
  assign out_wr_addr = wrAddr_q;
  assign out_wr_data = wrData_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: two 4x4 maps through a behavioural 3x3
// convolver (kernel 0..8) with selectable misbehaviour modes.
module tb_conv_sequencer;

  logic        clk, global_rst, start;
  logic        busy, done, err;
  logic        act_rd_en, conv_rst, conv_ce, out_wr_en;
  logic [9:0]  act_rd_addr, out_wr_addr;
  logic [15:0] act_rd_data, conv_act;
  logic [31:0] conv_op, out_wr_data;
  logic        conv_valid, conv_end;

  conv_sequencer #(
    .N(4), .K(3), .S(1), .NUM_MAPS(2), .ACT_W(16), .OUT_W(32), .ADDR_W(10), .DRAIN_MAX(16)
  ) dut (
    .clk(clk), .global_rst(global_rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .conv_rst(conv_rst), .conv_ce(conv_ce), .conv_act(conv_act),
    .conv_op(conv_op), .conv_valid(conv_valid), .conv_end(conv_end),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Activation RAM with one-cycle read latency.
  logic [15:0] ram [0:31];
  logic [15:0] ramQ;
  always @(posedge clk) if (act_rd_en) ramQ <= ram[act_rd_addr[4:0]];
  assign act_rd_data = ramQ;

  // Behavioural convolver: mode 0 normal, 1 never valid, 2 early end plus extra valids.
  int          mode = 0;
  logic [15:0] actBuf [0:15];
  int          mCnt, mIdx, extra;
  logic        mCe, mValid, mEnd;
  logic [31:0] mOp;

  function automatic int convAt(input int p);
    int r0, c0, s, idx;
    r0 = p / 4 - 2;
    c0 = p % 4 - 2;
    s  = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        idx = (r0 + r) * 4 + c0 + c;
        s += (3 * r + c) * int'(actBuf[idx[3:0]]);
      end
    return s;
  endfunction

  always @(posedge clk or posedge global_rst) begin
    if (global_rst || conv_rst) begin
      mCnt <= 0; mIdx <= 0; mCe <= 1'b0; extra <= 0;
      mValid <= 1'b0; mEnd <= 1'b0; mOp <= '0;
    end else begin
      mValid <= 1'b0;
      mEnd   <= 1'b0;
      mCe    <= conv_ce;
      mIdx   <= mCnt;
      if (conv_ce) begin
        if (mCnt < 16) actBuf[mCnt[3:0]] <= conv_act;
        mCnt <= mCnt + 1;
      end
      if (extra > 0) begin
        mValid <= 1'b1; mOp <= 32'd999; extra <= extra - 1;
      end else if (mCe && mode != 1 && mIdx < 16 && mIdx / 4 >= 2 && mIdx % 4 >= 2) begin
        mValid <= 1'b1;
        mOp    <= 32'(convAt(mIdx));
        mEnd   <= (mIdx == 15);
        if (mode == 2 && mIdx == 15) extra <= 2;
      end
      if (mCe && mode == 2 && mIdx == 12) mEnd <= 1'b1;
    end
  end
  assign conv_valid = mValid;
  assign conv_op    = mOp;
  assign conv_end   = mEnd;

  // Observer sampling 1 time unit after each rising edge.
  int          cyc = 0, actCnt = 0, rstCnt = 0, doneCnt = 0, doneCyc = 0;
  int          actRiseCyc = 0, wrCnt = 0, badWr = 0;
  logic        prevRd = 1'b0;
  logic [31:0] wrMem [0:7];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (act_rd_en) actCnt++;
    if (act_rd_en && !prevRd) actRiseCyc = cyc;
    prevRd = act_rd_en;
    if (conv_rst) rstCnt++;
    if (done) begin doneCnt++; doneCyc = cyc; end
    if (out_wr_en) begin
      wrCnt++;
      wrMem[out_wr_addr[2:0]] = out_wr_data;
      if (out_wr_data == 32'd999) badWr++;
    end
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_rd_en"}, act_rd_en, 0);
    checkOutput({tag, "_rd_addr"}, act_rd_addr, 0);
    checkOutput({tag, "_conv_rst"}, conv_rst, 0);
    checkOutput({tag, "_conv_ce"}, conv_ce, 0);
    checkOutput({tag, "_conv_act"}, conv_act, 0);
    checkOutput({tag, "_wr_en"}, out_wr_en, 0);
    checkOutput({tag, "_wr_addr"}, out_wr_addr, 0);
    checkOutput({tag, "_wr_data"}, out_wr_data, 0);
  endtask

  task automatic waitDone(input int maxCyc, input bit pokeStart);
    int n = 0;
    while (done !== 1'b1 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", done, 1);
    if (pokeStart) applyStimulus();
  endtask

  int w0, a0, r0, d0, b0;

  initial begin
    start = 1'b0;
    global_rst = 1'b1;
    for (int i = 0; i < 32; i++) ram[i] = 16'(i);
    repeat (3) @(negedge clk);
    checkZeros("por");
    global_rst = 1'b0;
    @(negedge clk);

    $display("[TB] two-map run with start poked mid-stream and on done");
    w0 = wrCnt; a0 = actCnt; r0 = rstCnt; d0 = doneCnt;
    applyStimulus();
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("clear_pulse", conv_rst, 1);
    checkOutput("no_read_in_clear", act_rd_en, 0);
    @(negedge clk);
    checkOutput("first_rd_en", act_rd_en, 1);
    checkOutput("first_rd_addr", act_rd_addr, 0);
    checkOutput("ce_lags_read", conv_ce, 0);
    @(negedge clk);
    checkOutput("first_ce", conv_ce, 1);
    checkOutput("rd_addr1", act_rd_addr, 1);
    @(negedge clk);
    checkOutput("conv_act_ram1", conv_act, 1);
    applyStimulus();
    checkOutput("rd_addr_after_poke", act_rd_addr, 3);
    checkOutput("no_clear_after_poke", conv_rst, 0);
    waitDone(300, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("idle_after_done_start", busy, 0);
    checkOutput("clear_pulses", rstCnt - r0, 2);
    checkOutput("rd_en_count", actCnt - a0, 32);
    checkOutput("done_pulses", doneCnt - d0, 1);
    checkOutput("write_count", wrCnt - w0, 8);
    checkOutput("err_clean", err, 0);
    checkOutput("out0", wrMem[0], 258);
    checkOutput("out1", wrMem[1], 294);
    checkOutput("out2", wrMem[2], 402);
    checkOutput("out3", wrMem[3], 438);
    checkOutput("out4", wrMem[4], 834);
    checkOutput("out5", wrMem[5], 870);
    checkOutput("out6", wrMem[6], 978);
    checkOutput("out7", wrMem[7], 1014);

    $display("[TB] silent convolver drain timeout");
    mode = 1;
    w0 = wrCnt; r0 = rstCnt; d0 = doneCnt;
    applyStimulus();
    waitDone(200, 1'b0);
    checkOutput("timeout_err", err, 1);
    repeat (4) @(negedge clk);
    checkOutput("timeout_latency", doneCyc - actRiseCyc, 32);
    checkOutput("timeout_no_writes", wrCnt - w0, 0);
    checkOutput("timeout_single_map", rstCnt - r0, 1);
    checkOutput("timeout_one_done", doneCnt - d0, 1);
    checkOutput("timeout_idle", busy, 0);

    $display("[TB] reset in fifth stream cycle then rerun");
    mode = 0;
    applyStimulus();
    checkOutput("err_cleared_on_start", err, 0);
    for (int n = 0; n < 20 && !(act_rd_en && act_rd_addr == 10'd4); n++) @(negedge clk);
    checkOutput("reached_stream5", act_rd_addr, 4);
    global_rst = 1'b1;
    #1;
    checkZeros("midrst");
    repeat (2) @(negedge clk);
    global_rst = 1'b0;
    @(negedge clk);
    w0 = wrCnt;
    applyStimulus();
    @(negedge clk);
    checkOutput("rerun_rd_en", act_rd_en, 1);
    checkOutput("rerun_addr0", act_rd_addr, 0);
    waitDone(300, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rerun_writes", wrCnt - w0, 8);
    checkOutput("rerun_err", err, 0);
    checkOutput("rerun_out0", wrMem[0], 258);
    checkOutput("rerun_out7", wrMem[7], 1014);

    $display("[TB] premature conv_end and surplus valids");
    mode = 2;
    w0 = wrCnt; b0 = badWr;
    applyStimulus();
    waitDone(300, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("early_end_err", err, 1);
    checkOutput("early_end_writes", wrCnt - w0, 8);
    checkOutput("surplus_dropped", badWr - b0, 0);
    checkOutput("early_out3", wrMem[3], 438);
    checkOutput("early_out4", wrMem[4], 834);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
